sumador_serie: RTL and testbench
================================

Name: sumador_serie

Overview:
Bit-serial N-bit adder built around one full-adder cell plus a carry flip-flop. It is the sequential stage directly downstream of the combinational full-adder cell and drives it one bit pair per clock, LSB first.
- Operands and carry-in are captured on a start pulse.
- The carry is registered between bits.
- The full sum and carry-out are presented with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32).

Ports:
clk  input  1  rising-edge clock, single domain.
rst  input  1  synchronous reset, active-high.
start  input  1  request; sampled only when busy=0.
a  input  WIDTH  operand A, captured on accepted start.
b  input  WIDTH  operand B, captured on accepted start.
cin  input  1  carry-in, captured on accepted start.
busy  output  1  high while an addition is in progress.
done  output  1  one-cycle pulse when sum/cout become valid.
sum  output  WIDTH  result, registered, held until next completion.
cout  output  1  final carry, registered, held until next completion.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry FF and bit counter all cleared.
  - rst has priority over every other input.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 -> load sa<=a, sb<=b, c<=cin, cnt<=0; go RUN. Otherwise stay.
  - RUN, one bit per edge:
    - s_bit = sa[0]^sb[0]^c.
    - c <= (sa[0]&sb[0]) | (c&(sa[0]^sb[0])).
    - sa, sb shift right by 1.
    - Internal result reg sr shifts right with s_bit inserted at MSB.
    - cnt <= cnt+1.
    - On the edge where cnt==WIDTH-1: copy the completed sr into sum, the new carry into cout; go FIN.
  - FIN: done=1 for exactly this cycle.
    - start=1 here is accepted as in IDLE (back-to-back) -> RUN.
    - Otherwise -> IDLE.
- busy=1 in RUN only; done=1 in FIN only; busy and done are never both 1.
- Latency: start accepted at edge E -> done high in the cycle after edge E+WIDTH. WIDTH=8 gives done 8 cycles after the start edge.
- sum/cout change only on the completion edge. During RUN they keep the previous result.
- start while busy=1 is ignored. a/b/cin may change freely after capture.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
- Counter width: clog2(WIDTH), minimum 1 bit. WIDTH=1 completes in a single RUN cycle.
- Reset mid-RUN: aborts the operation, no done pulse, sum/cout forced to 0.
- Simultaneous rst and start: reset wins; start is dropped.

Test Plan:
- WIDTH=1, all 8 {a,b,cin} combinations in sequence -> {cout,sum} matches the full-adder truth table (e.g. 1,1,1 -> cout=1, sum=1). done comes 1 cycle after each start edge.
- WIDTH=8: a=0x5A, b=0x3C, cin=1 -> sum=0x97, cout=0. busy high 8 cycles; done 8 cycles after the start edge; sum stays at its old value until completion.
- WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then 0xFF+0xFF, cin=1 -> sum=0xFF, cout=1.
- Start pulsed again mid-RUN with a=0x11, b=0x22 -> ignored; the original result is produced. Start held high during FIN with a=0x01, b=0x02 -> new operation begins with no IDLE cycle; sum=0x03 eight cycles later.
- rst asserted at the 4th RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows. A subsequent 0x10+0x20 -> sum=0x30.

Source files
------------

// File: rtl/sumador_serie.sv
// Bit-serial unsigned adder: one full-adder cell plus a carry flip-flop, walking
// the operands LSB first and publishing {cout,sum} with a one-cycle done pulse.
module sumador_serie #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             s_bit;
    logic             c_next;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] sr_shift;

    // Full-adder cell on the current LSB pair.
    assign s_bit  = sa_q[0] ^ sb_q[0] ^ c_q;
    assign c_next = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] ^ sb_q[0]));

    // Result bits enter at the MSB so the LSB lands in bit 0 after WIDTH steps.
    assign sr_shift = (sr_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // A new request is taken from IDLE and also from FIN (back-to-back).
    assign accept = start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sa_d    = a;
                    sb_d    = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                c_d   = c_next;
                sr_d  = sr_shift;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    sum_d   = sr_shift;
                    cout_d  = c_next;
                    state_d = FIN;
                end
            end
            FIN: begin
                done = 1'b1;
                if (accept) begin
                    sa_d    = a;
                    sb_d    = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_sumador_serie.sv
// Self-checking bench for sumador_serie: a WIDTH=1 instance for the truth table and a
// WIDTH=8 instance for directed, back-to-back, reset and random additions.
module tb_sumador_serie;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start8, cin8, busy8, done8, cout8;
    logic [W-1:0] a8, b8, sum8;
    logic         start1, a1, b1, cin1, busy1, done1, sum1, cout1;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W:0]   prev_res;

    sumador_serie #(.WIDTH(W)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    sumador_serie #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 addition; poke_at >= 0 re-asserts start during that RUN cycle.
    task automatic op8(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input int poke_at);
        logic [W:0] exp_res;
        exp_res = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tc);
        start8 = 1'b1; a8 = ta; b8 = tb_; cin8 = tc;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = W'($urandom); b8 = W'($urandom); cin8 = 1'($urandom);
        chk("run", {busy8, done8, cout8, sum8}, {2'b10, prev_res});
        for (int j = 1; j <= W; j++) begin
            if (j - 1 == poke_at) begin
                start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
            end
            @(posedge clk); #1;
            start8 = 1'b0;
            if (j < W)
                chk("run", {busy8, done8, cout8, sum8}, {2'b10, prev_res});
            else
                chk("done", {busy8, done8, cout8, sum8}, {2'b01, exp_res});
        end
        $display("w8 a=%h b=%h cin=%b -> cout=%b sum=%h (expect %b %h)",
                 ta, tb_, tc, cout8, sum8, exp_res[W], exp_res[W-1:0]);
        prev_res = exp_res;
    endtask

    task automatic idle8();
        @(posedge clk); #1;
        chk("idle", {busy8, done8, cout8, sum8}, {2'b00, prev_res});
    endtask

    task automatic op1(input logic ta, input logic tb_, input logic tc);
        logic [1:0] exp_res;
        exp_res = {1'b0, ta} + {1'b0, tb_} + {1'b0, tc};
        start1 = 1'b1; a1 = ta; b1 = tb_; cin1 = tc;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("w1_run", {busy1, done1}, 2'b10);
        @(posedge clk); #1;
        chk("w1_done", {busy1, done1, cout1, sum1}, {2'b01, exp_res});
        $display("w1 a=%b b=%b cin=%b -> cout=%b sum=%b (expect %b %b)",
                 ta, tb_, tc, cout1, sum1, exp_res[1], exp_res[0]);
    endtask

    initial begin
        logic [2:0] v;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        prev_res = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst8", {busy8, done8, cout8, sum8}, 0);
        chk("rst1", {busy1, done1, cout1, sum1}, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            op1(v[2], v[1], v[0]);
        end
        @(posedge clk); #1;
        chk("w1_idle", {busy1, done1}, 2'b00);

        op8(8'h5A, 8'h3C, 1'b1, -1);
        idle8();
        op8(8'hFF, 8'h01, 1'b0, -1);
        op8(8'hFF, 8'hFF, 1'b1, -1);
        idle8();

        op8(8'h40, 8'h33, 1'b0, 3);
        op8(8'h01, 8'h02, 1'b0, -1);
        idle8();

        // Abort in the 4th RUN cycle, with start raised alongside reset.
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h66; cin8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start8 = 1'b0;
        chk("rst_mid", {busy8, done8, cout8, sum8}, 0);
        prev_res = '0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk); #1;
            chk("no_done", {busy8, done8, cout8, sum8}, 0);
        end
        op8(8'h10, 8'h20, 1'b0, -1);
        idle8();

        for (int r = 0; r < 20; r++) begin
            op8(W'($urandom), W'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 2)) : -1);
            if ($urandom_range(0, 1) == 1) idle8();
        end
        idle8();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
